// File: rtl/game_round_ctrl.sv
// Round controller for the switch-entry sequence game: sequences CLEAR, SHOW,
// ENTRY, CHECK and RESULT phases, owns the sequence index and the user shift register.
module game_round_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_MISTAKES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       enter,
  input  logic       sw_bit,
  input  logic [7:0] gen_seq,
  input  logic [7:0] mistakes,
  output logic [2:0] index,
  output logic       show,
  output logic [7:0] user_seq,
  output logic [3:0] entry_cnt,
  output logic       clear,
  output logic       score_ld,
  output logic       mistakes_ld,
  output logic       game_over
);

  localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SHOW_W-1:0] SHOW_MAX = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        MIST_MAX = 8'(MAX_MISTAKES);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SHOW, ENTRY, CHECK, RESULT, OVER
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        index_q, index_d;
  logic [7:0]        userSeq_q, userSeq_d;
  logic [3:0]        entryCnt_q, entryCnt_d;
  logic [SHOW_W-1:0] showCnt_q, showCnt_d;
  logic [TO_W-1:0]   toCnt_q, toCnt_d;
  logic              timedOut_q, timedOut_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      index_q    <= '0;
      userSeq_q  <= '0;
      entryCnt_q <= '0;
      showCnt_q  <= '0;
      toCnt_q    <= '0;
      timedOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      userSeq_q  <= userSeq_d;
      entryCnt_q <= entryCnt_d;
      showCnt_q  <= showCnt_d;
      toCnt_q    <= toCnt_d;
      timedOut_q <= timedOut_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    userSeq_d  = userSeq_q;
    entryCnt_d = entryCnt_q;
    showCnt_d  = showCnt_q;
    toCnt_d    = toCnt_q;
    timedOut_d = timedOut_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d    = CLEAR;
          index_d    = '0;
          userSeq_d  = '0;
          entryCnt_d = '0;
        end
      end
      CLEAR: begin
        index_d    = '0;
        userSeq_d  = '0;
        entryCnt_d = '0;
        showCnt_d  = '0;
        state_d    = SHOW;
      end
      SHOW: begin
        toCnt_d    = '0;
        timedOut_d = 1'b0;
        if (showCnt_q == SHOW_MAX) begin
          showCnt_d = '0;
          state_d   = ENTRY;
        end else begin
          showCnt_d = showCnt_q + 1'b1;
        end
      end
      ENTRY: begin
        toCnt_d = toCnt_q + 1'b1;
        if (enter) begin
          userSeq_d  = {userSeq_q[6:0], sw_bit};
          entryCnt_d = entryCnt_q + 4'd1;
        end
        // The 8th strobe takes priority over a timeout expiring in the same cycle
        if (enter && (entryCnt_q == 4'd7)) begin
          state_d = CHECK;
        end else if ((TIMEOUT_CYCLES != 0) && (toCnt_q == TO_MAX)) begin
          timedOut_d = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        index_d = index_q + 3'd1;
        state_d = RESULT;
      end
      RESULT: begin
        if (mistakes >= MIST_MAX) begin
          state_d = OVER;
        end else begin
          userSeq_d  = '0;
          entryCnt_d = '0;
          showCnt_d  = '0;
          state_d    = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic seqMatch;
  assign seqMatch = !timedOut_q && (userSeq_q == gen_seq);

  assign index       = index_q;
  assign user_seq    = userSeq_q;
  assign entry_cnt   = entryCnt_q;
  assign show        = (state_q == SHOW);
  assign clear       = (state_q == CLEAR);
  assign score_ld    = (state_q == CHECK) && seqMatch;
  assign mistakes_ld = (state_q == CHECK) && !seqMatch;
  assign game_over   = (state_q == OVER);

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round controller for the switch-entry sequence game. It steps the game through its phases: clear the counters, show the computer sequence, collect eight user bits from the debounced switch, compare, and pulse the score or mistakes register load, until the game ends. It sits between the sequence generator, the checker-side registers (score, mistakes) and the debounced I/O, and owns the sequence index.

## Interface
Parameters:
- SHOW_CYCLES, default 50_000_000: number of cycles `show` stays high per round; must be ≥ 1.
- TIMEOUT_CYCLES, default 500_000_000: cycles allowed in ENTRY before the round is scored as a miss; 0 disables the timeout.
- MAX_MISTAKES, default 3: game over when `mistakes` ≥ this value; range 1–255.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled in IDLE and OVER to begin a game.
- `enter` in 1: single-cycle strobe from the debounced button; samples `sw_bit`.
- `sw_bit` in 1: debounced switch value.
- `gen_seq` in 8: computer sequence for the current `index`, combinational from the generator.
- `mistakes` in 8: current value of the mistakes register.
- `index` out 3: current sequence index, drives the generator.
- `show` out 1: high while the computer sequence is displayed.
- `user_seq` out 8: shift register of the entered bits.
- `entry_cnt` out 4: bits entered this round, 0–8.
- `clear` out 1: one-cycle pulse that clears the score and mistakes registers.
- `score_ld` out 1: one-cycle increment strobe for the score register.
- `mistakes_ld` out 1: one-cycle increment strobe for the mistakes register.
- `game_over` out 1: high in OVER.

## Operation
States and transitions:
- IDLE: all strobes low. If `start`=1, go to CLEAR.
- CLEAR, one cycle:
  - `clear`=1.
  - `index`, `user_seq` and `entry_cnt` are set to 0.
  - Go to SHOW.
- SHOW:
  - `show`=1 for exactly SHOW_CYCLES cycles, then go to ENTRY.
  - On entry to ENTRY, `user_seq`, `entry_cnt`, the timeout counter and the timed-out flag are all 0.
- ENTRY, on an `enter` strobe:
  - `user_seq` ← {`user_seq`[6:0], `sw_bit`}; the first bit entered ends up in `user_seq`[7].
  - `entry_cnt`++.
  - On the 8th strobe, go to CHECK.
- ENTRY timeout:
  - If TIMEOUT_CYCLES ≠ 0 and TIMEOUT_CYCLES cycles elapse in ENTRY without the 8th strobe, set timed_out and go to CHECK.
  - If the 8th strobe and timeout expiry fall in the same cycle, the strobe wins and timed_out stays clear.
- CHECK, one cycle:
  - If timed_out=0 and `user_seq` == `gen_seq`, `score_ld`=1; otherwise `mistakes_ld`=1. Exactly one of the two is high.
  - `index` ← `index`+1, wrapping 7→0, registered at the end of CHECK. The compare therefore uses the pre-increment `gen_seq`.
  - Go to RESULT.
- RESULT, one cycle (the mistakes register has updated by now):
  - If `mistakes` ≥ MAX_MISTAKES, go to OVER; otherwise go to SHOW.
- OVER:
  - `game_over`=1; `user_seq` and `index` are held.
  - If `start`=1, go to CLEAR.

Rules:
- `enter` is ignored outside ENTRY; `start` is ignored outside IDLE and OVER.
- Score wraps through the datapath's 8-bit adder. The controller does not saturate it.
- `reset` assertion in any state forces IDLE and all reset values immediately (asynchronously). Any partial entry is discarded.

## Timing
- Reset values: state IDLE; `index`=0, `user_seq`=0, `entry_cnt`=0; `show`, `clear`, `score_ld`, `mistakes_ld` and `game_over` all 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `enter` or `start` to any output.
- `start` high at edge N (IDLE): `clear` high in cycle N+1, `show` high in cycles N+2 … N+1+SHOW_CYCLES.
- 8th `enter` at edge M: `entry_cnt`=8 and CHECK in cycle M+1 (ld strobe); RESULT in M+2; SHOW or OVER from M+3.
- Minimum round length: 1 (CLEAR, first round only) + SHOW_CYCLES + 8 + 2 cycles.

## Test plan
Bench parameters: SHOW_CYCLES=4, TIMEOUT_CYCLES=20, MAX_MISTAKES=3.

- **Reset:** hold `reset`=0, then release → all outputs at their reset values. Assert `reset`=0 mid-ENTRY with `entry_cnt`=5 → IDLE in the same cycle, `entry_cnt`=0.
- **Correct round:** `start` pulse, `gen_seq`=8'hA5, enter bits 1,0,1,0,0,1,0,1 → `user_seq`=8'hA5, `score_ld` high for one cycle, `index` 0→1, `show` high again 3 cycles after the 8th strobe.
- **Wrong round:** `gen_seq`=8'h3C, enter 8'h3D → one `mistakes_ld` pulse, no `score_ld`.
- **Timeout:** enter 3 bits, then idle for 20 cycles → CHECK with `mistakes_ld`=1. A separate case puts the 8th strobe on the expiry cycle → `score_ld` when the bits match.
- **Game over:** three miss rounds, with the bench register incrementing `mistakes` → after the third RESULT, `game_over`=1 and `enter` is ignored. Then `start` → `clear` pulse, `index`=0.
- **Index wrap:** 8 correct rounds → `index` sequence 0,1,…,7,0; `enter` strobes during SHOW leave `entry_cnt`=0.
